// File: rtl/imem_ecc_load_port_if.sv
// Loader-write / fetch-read bus for imem_ecc_load_port.
// Latency: none, signal bundle only.
// Backpressure: none; writes and reads are fire-and-forget strobes.
interface imem_ecc_load_port_if #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
);
  logic          imem_we;
  logic [31:0]   imem_waddr;
  logic [31:0]   imem_wdata;
  logic          loader_done_in;
  logic          rd_en;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          s_err;
  logic          d_err;
  logic          load_active;
  logic          load_complete;
  logic          wr_reject;
  logic [IW:0]   word_count;
  logic [15:0]   s_err_count;
  logic [15:0]   d_err_count;

  // Loader and fetch side.
  modport master (
    output imem_we, imem_waddr, imem_wdata, loader_done_in, rd_en, rd_addr,
    input  rd_data, rd_valid, s_err, d_err, load_active, load_complete,
           wr_reject, word_count, s_err_count, d_err_count
  );

  // Memory side.
  modport slave (
    input  imem_we, imem_waddr, imem_wdata, loader_done_in, rd_en, rd_addr,
    output rd_data, rd_valid, s_err, d_err, load_active, load_complete,
           wr_reject, word_count, s_err_count, d_err_count
  );
endinterface

// File: rtl/imem_ecc_load_port.sv
// SECDED(39,32) instruction memory: loaded word by word, then serves corrected fetches.
// Latency: 1 cycle from rd_en to rd_data/rd_valid; writes land on the next edge.
// Backpressure: none; dropped writes pulse wr_reject. IMEM_SCRUB_EN adds scrub-on-correct.
module imem_ecc_load_port #(
  parameter int DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_ecc_load_port_if.slave  bus
);
  localparam int          IW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Codeword bit p (1..38) contributes p to the syndrome when set.
  function automatic logic [5:0] ecc_syndrome(input logic [38:0] cw);
    logic [5:0] s;
    s = '0;
    for (int p = 1; p < 39; p++) begin
      if (cw[p]) s = s ^ 6'(p);
    end
    return s;
  endfunction

  // Data occupies the non-power-of-two positions, LSB first.
  function automatic logic [31:0] ecc_data(input logic [38:0] cw);
    logic [31:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [38:0] ecc_encode(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  s;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    // With check bits zero, the syndrome is exactly the check-bit pattern needed.
    s = ecc_syndrome(cw);
    for (int b = 0; b < 6; b++) cw[1 << b] = s[b];
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  logic [38:0]      mem [DEPTH];
  state_t           state_q, state_d;
  logic [DEPTH-1:0] valid_q;
  logic [IW:0]      word_count_q;
  logic             wr_reject_q, rd_valid_q, s_err_q, d_err_q;
  logic [31:0]      rd_data_q;
  logic [15:0]      s_cnt_q, d_cnt_q;

  logic [IW-1:0]    wr_idx, rd_idx;
  logic             wr_legal, wr_accept, rd_illegal, rd_go;
  logic [38:0]      rd_cw, fix_cw;
  logic [5:0]       syn;
  logic             par;
  logic [31:0]      rd_data_d;
  logic             s_err_d, d_err_d;

`ifdef IMEM_SCRUB_EN
  logic             scrub_vld_q;
  logic [IW-1:0]    scrub_idx_q;
  logic [38:0]      scrub_cw_q;
`endif

  assign wr_idx     = bus.imem_waddr[IW+1:2];
  assign wr_legal   = (bus.imem_waddr[1:0] == 2'b00) && (bus.imem_waddr[31:IW+2] == '0);
  assign rd_idx     = bus.rd_addr[IW+1:2];
  assign rd_illegal = (bus.rd_addr[1:0] != 2'b00) || (bus.rd_addr[31:IW+2] != '0);

  // FSM next state and write acceptance; done in IDLE beats a same-cycle write.
  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    rd_go     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_accept = bus.imem_we && wr_legal && !bus.loader_done_in;
        if (bus.loader_done_in) state_d = RUN;
        else if (wr_accept)     state_d = LOAD;
      end
      LOAD: begin
        wr_accept = bus.imem_we && wr_legal;
        if (bus.loader_done_in) state_d = RUN;
      end
      RUN: begin
        rd_go = bus.rd_en;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read decode: pick the codeword (scrub bypass first), then classify by syndrome/parity.
  always_comb begin
    rd_cw = mem[rd_idx];
`ifdef IMEM_SCRUB_EN
    if (scrub_vld_q && (scrub_idx_q == rd_idx)) rd_cw = scrub_cw_q;
`endif
    syn       = ecc_syndrome(rd_cw);
    par       = ^rd_cw;
    fix_cw    = rd_cw;
    rd_data_d = ecc_data(rd_cw);
    s_err_d   = 1'b0;
    d_err_d   = 1'b0;
    if (rd_illegal) begin
      rd_data_d = NOP;
      d_err_d   = 1'b1;
    end else if (!valid_q[rd_idx]) begin
      rd_data_d = NOP;
    end else if (par) begin
      if (syn == 6'd0) begin
        fix_cw[0] = ~rd_cw[0];
        s_err_d   = 1'b1;
      end else if (syn > 6'd38) begin
        d_err_d = 1'b1;
      end else begin
        fix_cw[syn] = ~rd_cw[syn];
        rd_data_d   = ecc_data(fix_cw);
        s_err_d     = 1'b1;
      end
    end else if (syn != 6'd0) begin
      d_err_d = 1'b1;
    end
  end

  // Codeword storage: loader writes, plus scrub write-back when enabled; never reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_idx] <= ecc_encode(bus.imem_wdata);
`ifdef IMEM_SCRUB_EN
    else if (scrub_vld_q) mem[scrub_idx_q] <= scrub_cw_q;
`endif
  end

  // Valid bits, count, reject pulse, registered read outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      word_count_q <= '0;
      wr_reject_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      s_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      s_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      wr_reject_q <= bus.imem_we && !wr_accept;
      if (wr_accept) begin
        valid_q[wr_idx] <= 1'b1;
        if (!valid_q[wr_idx]) word_count_q <= word_count_q + 1'b1;
      end
      rd_valid_q <= rd_go;
      rd_data_q  <= rd_go ? rd_data_d : '0;
      s_err_q    <= rd_go && s_err_d;
      d_err_q    <= rd_go && d_err_d;
      if (rd_go && s_err_d && (s_cnt_q != 16'hFFFF)) s_cnt_q <= s_cnt_q + 1'b1;
      if (rd_go && d_err_d && (d_cnt_q != 16'hFFFF)) d_cnt_q <= d_cnt_q + 1'b1;
    end
  end

`ifdef IMEM_SCRUB_EN
  // Capture the corrected codeword so it is written back during the output cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_vld_q <= 1'b0;
      scrub_idx_q <= '0;
      scrub_cw_q  <= '0;
    end else begin
      scrub_vld_q <= rd_go && s_err_d;
      scrub_idx_q <= rd_idx;
      scrub_cw_q  <= fix_cw;
    end
  end
`endif

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.s_err         = s_err_q;
  assign bus.d_err         = d_err_q;
  assign bus.load_active   = (state_q == LOAD);
  assign bus.load_complete = (state_q == RUN);
  assign bus.wr_reject     = wr_reject_q;
  assign bus.word_count    = word_count_q;
  assign bus.s_err_count   = s_cnt_q;
  assign bus.d_err_count   = d_cnt_q;
endmodule

// File: tb/tb_imem_ecc_load_port.sv
// Randomized load/read bench for imem_ecc_load_port with an array-based reference model.
// Latency: expects fetch results one cycle after rd_en, reject pulse one cycle after the write.
// Backpressure: none; faults are injected by flipping bits of dut.mem directly.
module tb_imem_ecc_load_port;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_ecc_load_port_if #(.DEPTH(DEPTH)) bus ();
  imem_ecc_load_port #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_data [DEPTH];
  bit          m_vld  [DEPTH];
  int          m_cnt, m_scnt, m_dcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_cnt = 0;
  endtask

  function automatic bit addr_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  // Data bit carried by codeword position pos: positions 1,2,4,... are check bits.
  function automatic int data_bit_of(input int pos);
    if (pos == 0 || (pos & (pos - 1)) == 0) return -1;
    return pos - 2 - ($clog2(pos + 1) - 1);
  endfunction

  function automatic logic [31:0] flip_data(input logic [31:0] d, input int pos);
    logic [31:0] r;
    int          b;
    r = d;
    b = data_bit_of(pos);
    if (b >= 0) r[b] = ~r[b];
    return r;
  endfunction

  task automatic flip(input int idx, input int pos);
    dut.mem[idx][pos] = ~dut.mem[idx][pos];
  endtask

  // Loader write with model update; checks reject pulse and count afterwards.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic done, input bit accept_ok);
    bit acc;
    bus.imem_we = 1'b1; bus.imem_waddr = a; bus.imem_wdata = d; bus.loader_done_in = done;
    cyc();
    bus.imem_we = 1'b0;
    acc = accept_ok && addr_legal(a);
    if (acc) begin
      if (!m_vld[a / 4]) m_cnt++;
      m_vld[a / 4]  = 1'b1;
      m_data[a / 4] = d;
    end
    chk({tag, ".rej"}, bus.wr_reject, !acc);
    chk({tag, ".cnt"}, bus.word_count, m_cnt);
  endtask

  // Issue one fetch (rd_en left high for back-to-back use) and check its result.
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] ed,
                          input bit es, input bit ed_err);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    cyc();
    if (es && m_scnt < 16'hFFFF) m_scnt++;
    if (ed_err && m_dcnt < 16'hFFFF) m_dcnt++;
    chk({tag, ".vld"},  bus.rd_valid, 1);
    chk({tag, ".dat"},  bus.rd_data, ed);
    chk({tag, ".serr"}, bus.s_err, es);
    chk({tag, ".derr"}, bus.d_err, ed_err);
    chk({tag, ".scnt"}, bus.s_err_count, m_scnt);
    chk({tag, ".dcnt"}, bus.d_err_count, m_dcnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_clear();
    m_scnt = 0;
    m_dcnt = 0;
  endtask

  initial begin
    logic [31:0] a, d, exp_d;
    int          idx, kind, tgt;
    bit          we, re, exp_s, exp_de;

    bus.imem_we = 0; bus.imem_waddr = 0; bus.imem_wdata = 0; bus.loader_done_in = 0;
    bus.rd_en = 0; bus.rd_addr = 0;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst.active", bus.load_active, 0);
    chk("rst.cmpl",   bus.load_complete, 0);
    chk("rst.rvld",   bus.rd_valid, 0);
    chk("rst.cnt",    bus.word_count, 0);
    chk("rst.rej",    bus.wr_reject, 0);
    chk("rst.scnt",   bus.s_err_count, 0);
    chk("rst.dcnt",   bus.d_err_count, 0);
    rst = 1'b0;
    model_clear(); m_scnt = 0; m_dcnt = 0;

    // done in IDLE wins over a simultaneous legal write
    do_write("idle_done", 32'h0, 32'h1234_5678, 1'b1, 1'b0);
    chk("idle_done.cmpl", bus.load_complete, 1);
    bus.loader_done_in = 1'b0;
    cyc();
    chk("run_sticky", bus.load_complete, 1);

    // overwrite does not recount; reset mid-load discards everything
    do_reset();
    bus.rd_en = 1'b1; bus.rd_addr = 32'h0;
    cyc();
    chk("idle_rd.vld", bus.rd_valid, 0);
    bus.rd_en = 1'b0;
    do_write("ow1", 32'h0, 32'hAAAA_0001, 1'b0, 1'b1);
    chk("ow1.active", bus.load_active, 1);
    do_write("ow2", 32'h0, 32'hBBBB_0002, 1'b0, 1'b1);
    do_reset();
    chk("rstmid.active", bus.load_active, 0);
    chk("rstmid.cnt",    bus.word_count, 0);

    // main load: directed words, an overwrite, then a random mix of legal/illegal writes
    do_write("w0", 32'h0, 32'h00A0_0493, 1'b0, 1'b1);
    do_write("w1", 32'h4, 32'h0080_0513, 1'b0, 1'b1);
    do_write("w3a", 32'hC, $urandom, 1'b0, 1'b1);
    do_write("w3b", 32'hC, $urandom, 1'b0, 1'b1);
    chk("w3b.cnt3", bus.word_count, 3);
    for (int i = 0; i < 80; i++) begin
      we   = ($urandom % 4) != 0;
      re   = $urandom % 2;
      kind = $urandom % 10;
      idx  = $urandom_range(3, DEPTH - 1);
      if (kind < 7)      a = idx * 4;
      else if (kind < 9) a = idx * 4 + $urandom_range(1, 3);
      else               a = 4 * DEPTH + ($urandom % 1024) * 4;
      d = $urandom;
      bus.rd_en = re; bus.rd_addr = a;
      if (we) begin
        do_write("rnd_w", a, d, 1'b0, 1'b1);
      end else begin
        cyc();
        chk("rnd_idle.rej", bus.wr_reject, 0);
      end
      chk("load_rd.vld", bus.rd_valid, 0);
      chk("load.active", bus.load_active, 1);
    end
    bus.rd_en = 1'b0;
    do_write("final", 4 * (DEPTH - 1), 32'hCAFE_F00D, 1'b1, 1'b1);
    chk("final.cmpl",   bus.load_complete, 1);
    chk("final.active", bus.load_active, 0);
    bus.loader_done_in = 1'b0;
    cyc();
    chk("done_low.cmpl", bus.load_complete, 1);

    // directed read, then random back-to-back reads against the model
    rd_check("rd4", 32'h4, 32'h0080_0513, 0, 0);
    for (int i = 0; i < 200; i++) begin
      re   = ($urandom % 5) != 0;
      kind = $urandom % 10;
      if (kind < 8)      a = $urandom_range(0, DEPTH - 1) * 4;
      else if (kind < 9) a = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
      else               a = 4 * DEPTH + ($urandom % 4096) * 4;
      if (!re) begin
        bus.rd_en = 1'b0;
        cyc();
        chk("rnd_noread.vld", bus.rd_valid, 0);
      end else if (!addr_legal(a)) begin
        rd_check("rnd_ill", a, NOP, 0, 1);
      end else if (!m_vld[a / 4]) begin
        rd_check("rnd_unw", a, NOP, 0, 0);
      end else begin
        rd_check("rnd_ok", a, m_data[a / 4], 0, 0);
      end
    end
    bus.rd_en = 1'b0;
    cyc();

    // single-bit data error, then a back-to-back and a later re-read
    flip(0, 7);
    rd_check("se1", 32'h0, 32'h00A0_0493, 1, 0);
`ifdef IMEM_SCRUB_EN
    rd_check("se_b2b", 32'h0, 32'h00A0_0493, 0, 0);
    bus.rd_en = 1'b0; cyc();
    rd_check("se_again", 32'h0, 32'h00A0_0493, 0, 0);
`else
    rd_check("se_b2b", 32'h0, 32'h00A0_0493, 1, 0);
    bus.rd_en = 1'b0; cyc();
    rd_check("se_again", 32'h0, 32'h00A0_0493, 1, 0);
`endif
    bus.rd_en = 1'b0; cyc();

    // overall-parity bit alone flipped: data intact, still a corrected error
    flip(3, 0);
    rd_check("par0", 32'hC, m_data[3], 1, 0);
    bus.rd_en = 1'b0; cyc();

    // double error returns raw data bits
    flip(1, 3); flip(1, 20);
    exp_d = flip_data(flip_data(32'h0080_0513, 3), 20);
    rd_check("de", 32'h4, exp_d, 0, 1);
    chk("de.rawdiff", bus.rd_data != 32'h0080_0513, 1);

    // triple flip giving syndrome beyond the codeword with odd parity
    flip(DEPTH - 1, 35); flip(DEPTH - 1, 6); flip(DEPTH - 1, 9);
    exp_d = flip_data(flip_data(flip_data(32'hCAFE_F00D, 35), 6), 9);
    rd_check("synhi", 4 * (DEPTH - 1), exp_d, 0, 1);
    bus.rd_en = 1'b0; cyc();

    // writes after RUN are all rejected
    do_write("run_mis", 32'h2,   32'h1, 1'b0, 1'b0);
    do_write("run_oor", 32'h100, 32'h2, 1'b0, 1'b0);
    do_write("run_ok",  32'h8,   32'h3, 1'b0, 1'b0);
    rd_check("unw8", 32'h8, NOP, 0, 0);
    bus.rd_en = 1'b0; cyc();

    // drive s_err_count to saturation, alternating two corrupted entries
    kind = 0;
    while (m_scnt < 16'hFFFF) begin
      tgt = (kind % 2 == 0) ? 0 : 3;
`ifdef IMEM_SCRUB_EN
      flip(tgt, 7);
`endif
      bus.rd_en = 1'b1; bus.rd_addr = tgt * 4;
      cyc();
      m_scnt++;
      kind++;
    end
    chk("sat.scnt", bus.s_err_count, 16'hFFFF);
    tgt = (kind % 2 == 0) ? 0 : 3;
`ifdef IMEM_SCRUB_EN
    flip(tgt, 7);
`endif
    rd_check("sat_hold", tgt * 4, m_data[tgt], 1, 0);
    bus.rd_en = 1'b0;
    cyc();
    chk("sat_end.vld", bus.rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
